vjtag_bus_target: RTL
=====================

// Module: vjtag_bus_target
// PURPOSE
//  Bus responder for the VJTAG host system bus: a DEPTH=2**AW x DW register-array memory
//  that accepts write/read requests, stretches them with ready, returns read data with rrvalid.
//  Sits on clk side opposite the JTAG-driven bus initiator; used as bring-up/test target.
// PARAMETERS
//  AW        8   address width; memory depth 2**AW words
//  DW        8   data width
//  RD_LAT    1   cycles from read accept to rrvalid pulse; legal 1..15
//  WAIT_CYC  2   wait cycles inserted before ready (only with VJTAG_TGT_WAIT_EN); legal 1..255
// PORTS
//  clk      in   1    system clock
//  rst_n    in   1    asynchronous active-low reset
//  address  in   AW   request address, sampled at accept
//  wvalid   in   1    write request, held by initiator until wready
//  wdata    in   DW   write data, sampled at accept
//  wready   out  1    write accept
//  rvalid   in   1    read request, held by initiator until rready
//  rready   out  1    read accept
//  rrvalid  out  1    read response valid, 1-cycle pulse
//  rdata    out  DW   read data, valid with rrvalid, held until next response
//  wr_cnt   out  16   accepted-write counter, wraps 0xFFFF->0
//  rd_cnt   out  16   completed-read counter (counts rrvalid), wraps
// BEHAVIOUR
//  Clock clk, reset rst_n asynchronous active-low. Reset: wready=rready=0 (w/o macro: 1 after
//   reset release, see IDLE), rrvalid=0, rdata=0, wr_cnt=rd_cnt=0, state=IDLE. Memory not reset.
//  Accept: write when wvalid&&wready at posedge; read when rvalid&&rready. wready/rready are
//   identical, combinational from state only (never from valid).
//  Priority: wvalid&&rvalid together -> write accepted, read stays pending (ready drops).
//  FSM:
//   IDLE : w/o macro ready=1; write accept -> mem[address]<=wdata, wr_cnt++, stay IDLE;
//          read accept -> capture mem[address], load lat counter RD_LAT-1 -> RESP.
//          With macro ready=0; any valid -> WAIT, wait counter<=WAIT_CYC-1.
//   WAIT : ready=0; counter 0 -> GRANT else decrement. Valid dropping mid-wait is ignored.
//   GRANT: ready=1 one cycle; write accept -> IDLE; read accept -> RESP; no valid -> IDLE.
//   RESP : ready=0; lat counter 0 -> rrvalid=1, rdata=captured word, rd_cnt++ -> IDLE,
//          else decrement.
//  Latency: write effective 1 cycle after accept; read accepted at edge N -> rrvalid high in
//   cycle N+RD_LAT. No new request accepted while a read is outstanding (one outstanding).
//  Read-after-write: write accepted at N, read accepted at N+1 returns the new data.
//  Address uses all AW bits, no out-of-range case. Counters are plain +1 mod 2**16.
//  Reset mid-op: state->IDLE, rrvalid cleared, pending read dropped, in-flight write lost
//   if reset asserts before its accept edge.
// CONFIGURATION
//  VJTAG_TGT_WAIT_EN defined: IDLE->WAIT->GRANT path, each request sees WAIT_CYC+1 cycles
//   of ready=0 after valid first seen (1 IDLE sample + WAIT_CYC), then a 1-cycle ready.
//  Undefined: WAIT/GRANT not built, WAIT_CYC unused, ready=1 in IDLE, zero-wait accept.
// TESTING
//  1 reset, w/o macro: write 0x5A to addr 0x10 -> wready=1 same cycle, wr_cnt=1;
//    read 0x10, RD_LAT=1 -> rrvalid next cycle, rdata=0x5A, rd_cnt=1.
//  2 RD_LAT=4: read accept at edge N -> rrvalid only in cycle N+4, rready=0 cycles N+1..N+4.
//  3 wvalid&rvalid same cycle, addr 0x20, wdata 0xC3 -> write first, then read returns 0xC3.
//  4 macro on, WAIT_CYC=3: wvalid held -> wready low 4 cycles, high 1 cycle, data stored.
//  5 rst_n low during RESP (RD_LAT=8) -> rrvalid never pulses, rd_cnt unchanged, IDLE after.
//  6 65536 writes -> wr_cnt wraps to 0; addr 0xFF write/read back 0xA5 (top address).

Source files
------------

// File: rtl/vjtag_bus_target_if.sv
// Bus bundle between the JTAG-driven initiator and the vjtag_bus_target responder.
// The master modport belongs to the initiator and the slave modport to the target.
`timescale 1ns/1ps
interface vjtag_bus_target_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] address;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wready;
    logic          rvalid;
    logic          rready;
    logic          rrvalid;
    logic [DW-1:0] rdata;

    modport master (
        output address, wvalid, wdata, rvalid,
        input  wready, rready, rrvalid, rdata
    );

    modport slave (
        input  address, wvalid, wdata, rvalid,
        output wready, rready, rrvalid, rdata
    );
endinterface

// File: rtl/vjtag_bus_target.sv
// Register-array bus responder for the VJTAG host bus: 2**AW x DW memory, one outstanding read.
// Optional wait-state insertion before ready when VJTAG_TGT_WAIT_EN is defined.
`timescale 1ns/1ps
module vjtag_bus_target #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int RD_LAT   = 1,
    parameter int WAIT_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    vjtag_bus_target_if.slave   bus,
    output logic [15:0]         wr_cnt,
    output logic [15:0]         rd_cnt
);

    if (RD_LAT < 1 || RD_LAT > 15 || WAIT_CYC < 1 || WAIT_CYC > 255) begin : g_param_check
        $error("vjtag_bus_target: RD_LAT must be 1..15 and WAIT_CYC 1..255");
    end

    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

`ifdef VJTAG_TGT_WAIT_EN
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYC - 1);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_RESP} state_t;
    logic [7:0] wcnt_q, wcnt_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

    state_t        state_q, state_d;
    logic [3:0]    lat_q, lat_d;
    logic [DW-1:0] cap_q, cap_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rrvalid_q, rrvalid_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic          ready;
    logic          wr_acc, rd_acc;
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
`ifdef VJTAG_TGT_WAIT_EN
            wcnt_q    <= '0;
`endif
            cap_q     <= '0;
            rdata_q   <= '0;
            rrvalid_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
`ifdef VJTAG_TGT_WAIT_EN
            wcnt_q    <= wcnt_d;
`endif
            cap_q     <= cap_d;
            rdata_q   <= rdata_d;
            rrvalid_q <= rrvalid_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[bus.address] <= bus.wdata;
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
`ifdef VJTAG_TGT_WAIT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef VJTAG_TGT_WAIT_EN
                if (bus.wvalid || bus.rvalid) begin
                    state_d = S_WAIT;
                    wcnt_d  = WAIT_INIT;
                end
`else
                if (rd_acc) begin
                    state_d = S_RESP;
                    lat_d   = LAT_INIT;
                end
`endif
            end
`ifdef VJTAG_TGT_WAIT_EN
            S_WAIT: begin
                if (wcnt_q == '0) state_d = S_GRANT;
                else              wcnt_d  = wcnt_q - 8'd1;
            end
            S_GRANT: begin
                if (rd_acc) begin
                    state_d = S_RESP;
                    lat_d   = LAT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            S_RESP: begin
                if (lat_q == '0) state_d = S_IDLE;
                else             lat_d   = lat_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is a function of state only; it is also held low while reset is asserted.
    always_comb begin
`ifdef VJTAG_TGT_WAIT_EN
        ready = rst_n && (state_q == S_GRANT);
`else
        ready = rst_n && (state_q == S_IDLE);
`endif
        wr_acc = bus.wvalid && ready;
        rd_acc = bus.rvalid && ready && !bus.wvalid;
    end

    // The response registers load on the edge entering the last RESP cycle, so rrvalid and
    // rdata are both registered and appear exactly RD_LAT cycles after the accept edge.
    always_comb begin
        cap_d     = rd_acc ? mem_q[bus.address] : cap_q;
        rrvalid_d = (state_d == S_RESP) && (lat_d == '0);
        rdata_d   = rrvalid_d ? cap_d : rdata_q;
        wr_cnt_d  = wr_cnt_q + 16'(wr_acc);
        rd_cnt_d  = rd_cnt_q + 16'(rrvalid_d);
    end

    assign bus.wready  = ready;
    assign bus.rready  = ready;
    assign bus.rrvalid = rrvalid_q;
    assign bus.rdata   = rdata_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;

endmodule
